imm_seq_ctrl: RTL

IMM_SEQ_CTRL -- requirements
Module: imm_seq_ctrl

---
 rtl/imm_seq_ctrl.sv | 213 +++++++++++++++++++++
 1 files changed

// File: rtl/imm_seq_ctrl.sv
// Multi-cycle RISC-V style control sequencer with a bounded memory handshake and fault trapping.
// Define UPPER_IMM_EN to enable LUI/AUIPC handling; without it those opcodes trap as illegal.
module imm_seq_ctrl #(
    parameter int MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [2:0] ImmSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUOp,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] fault
);

    typedef enum logic [3:0] {
        FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC_R,
        EXEC_I, ALUWB, BRANCH, JAL, UPPER, TRAP
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;

    localparam logic [1:0] FLT_NONE    = 2'b00;
    localparam logic [1:0] FLT_ILLEGAL = 2'b01;
    localparam logic [1:0] FLT_TIMEOUT = 2'b10;

    localparam logic [7:0] TMO = 8'(MEM_TIMEOUT);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [7:0] r_wait_cnt;
    logic [1:0] r_fault;
    logic [1:0] w_fault_nxt;
    logic       w_wait_state;
    logic       w_timeout;

    // The counter holds the number of cycles already spent waiting in the current state,
    // so a ready on the cycle where it equals MEM_TIMEOUT is still accepted.
    assign w_wait_state = (r_state == FETCH) || (r_state == MEMRD) || (r_state == MEMWR);
    assign w_timeout    = w_wait_state && !mem_ready && (r_wait_cnt == TMO);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= FETCH;
            r_wait_cnt <= 8'd0;
            r_fault    <= FLT_NONE;
        end else begin
            r_state <= w_state_nxt;
            r_fault <= w_fault_nxt;
            if (w_state_nxt != r_state) begin
                r_wait_cnt <= 8'd0;
            end else if (w_wait_state && !mem_ready) begin
                r_wait_cnt <= r_wait_cnt + 8'd1;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_fault_nxt = r_fault;
        ImmSrc      = 3'b000;
        ALUSrcA     = 2'b00;
        ALUSrcB     = 2'b00;
        ResultSrc   = 2'b00;
        ALUOp       = 2'b00;
        PCWrite     = 1'b0;
        AdrSrc      = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegWrite    = 1'b0;

        case (r_state)
            FETCH: begin
                MemRead   = 1'b1;
                ALUSrcB   = 2'b10;
                ResultSrc = 2'b10;
                if (mem_ready) begin
                    IRWrite     = 1'b1;
                    PCWrite     = 1'b1;
                    w_state_nxt = DECODE;
                end else if (w_timeout) begin
                    w_state_nxt = TRAP;
                    w_fault_nxt = FLT_TIMEOUT;
                end
            end
            DECODE: begin
                ImmSrc  = 3'b101;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                case (op)
                    OP_LOAD, OP_STORE: w_state_nxt = MEMADR;
                    OP_R:              w_state_nxt = EXEC_R;
                    OP_I:              w_state_nxt = EXEC_I;
                    OP_BR:             w_state_nxt = BRANCH;
                    OP_JAL:            w_state_nxt = JAL;
`ifdef UPPER_IMM_EN
                    OP_LUI, OP_AUIPC:  w_state_nxt = UPPER;
`endif
                    default: begin
                        w_state_nxt = TRAP;
                        w_fault_nxt = FLT_ILLEGAL;
                    end
                endcase
            end
            MEMADR: begin
                ImmSrc      = (op == OP_STORE) ? 3'b001 : 3'b000;
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                w_state_nxt = (op == OP_STORE) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                AdrSrc  = 1'b1;
                MemRead = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = MEMWB;
                end else if (w_timeout) begin
                    w_state_nxt = TRAP;
                    w_fault_nxt = FLT_TIMEOUT;
                end
            end
            MEMWR: begin
                AdrSrc   = 1'b1;
                MemWrite = 1'b1;
                if (mem_ready) begin
                    w_state_nxt = FETCH;
                end else if (w_timeout) begin
                    w_state_nxt = TRAP;
                    w_fault_nxt = FLT_TIMEOUT;
                end
            end
            MEMWB: begin
                ResultSrc   = 2'b01;
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
            EXEC_R: begin
                ALUSrcA     = 2'b10;
                ALUOp       = 2'b10;
                w_state_nxt = ALUWB;
            end
            EXEC_I: begin
                ALUSrcA     = 2'b10;
                ALUSrcB     = 2'b01;
                ALUOp       = 2'b10;
                w_state_nxt = ALUWB;
            end
            ALUWB: begin
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
            BRANCH: begin
                ALUSrcA = 2'b10;
                ALUOp   = 2'b01;
                case (funct3)
                    3'b000:  PCWrite = zero;
                    3'b001:  PCWrite = ~zero;
                    default: PCWrite = 1'b0;
                endcase
                w_state_nxt = FETCH;
            end
            JAL: begin
                ImmSrc      = 3'b110;
                ALUSrcA     = 2'b01;
                ALUSrcB     = 2'b10;
                PCWrite     = 1'b1;
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
`ifdef UPPER_IMM_EN
            UPPER: begin
                ImmSrc      = 3'b010;
                ALUSrcA     = (op == OP_LUI) ? 2'b11 : 2'b01;
                ALUSrcB     = 2'b01;
                RegWrite    = 1'b1;
                w_state_nxt = FETCH;
            end
`endif
            TRAP: w_state_nxt = TRAP;
            default: w_state_nxt = FETCH;
        endcase

        // Strobes stay quiet for the whole time reset is held, whatever state is current.
        if (rst) begin
            PCWrite  = 1'b0;
            AdrSrc   = 1'b0;
            MemRead  = 1'b0;
            MemWrite = 1'b0;
            IRWrite  = 1'b0;
            RegWrite = 1'b0;
        end
    end

    assign fault = r_fault;

endmodule
